toggle_period_meter: RTL and testbench

//   Receive-side companion to the LED clock divider. It samples a slow, asynchronous toggling signal
//   (e.g. a divided clock looped back from a pin) and measures its period and high time in clk cycles.
//   It also flags when the signal has stopped toggling. Sits between the pin and bring-up status logic.

---
 rtl/toggle_period_meter.sv | 137 +++++++++++++
 tb/tb_toggle_period_meter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/toggle_period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : toggle_period_meter
//  Description : Measures period and high time, in clk cycles, of a slow
//                asynchronous toggling input. It also flags when the input
//                has stopped producing rising edges.
//  Ports       : clk         system clock
//                rst_n       asynchronous active-low reset
//                sig_in      asynchronous toggling input under measurement
//                period      cycles between the last two rising edges
//                high_time   cycles from the measured rising edge to the
//                            following falling edge
//                meas_valid  1-cycle pulse, period/high_time just updated
//                timeout     level, no rising edge for TIMEOUT cycles
//  Revision    : 1.0  initial release
// ============================================================================
module toggle_period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             timeout
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

    state_t                 state_q,      state_d;
    logic [SYNC_STAGES-1:0] sync_q,       sync_d;
    logic                   prev_q,       prev_d;
    logic [CNT_W-1:0]       cnt_q,        cnt_d;
    logic [CNT_W-1:0]       hi_lat_q,     hi_lat_d;
    logic [CNT_W-1:0]       period_q,     period_d;
    logic [CNT_W-1:0]       high_time_q,  high_time_d;
    logic                   meas_valid_q, meas_valid_d;
    logic                   timeout_q,    timeout_d;

    logic w_s;
    logic w_rise;
    logic w_fall;

    // Synchronizer shift chain and edge detection on its last stage
    assign sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
    assign w_s    = sync_q[SYNC_STAGES-1];
    assign prev_d = w_s;
    assign w_rise = w_s & ~prev_q;
    assign w_fall = ~w_s & prev_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_lat_d     = hi_lat_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        meas_valid_d = 1'b0;
        timeout_d    = timeout_q;

        case (state_q)
            IDLE: begin
                // Only a rising edge arms the meter; the first interval is
                // partial, so it produces no measurement.
                if (w_rise) begin
                    state_d   = MEASURE;
                    cnt_d     = c_one;
                    hi_lat_d  = '0;
                    timeout_d = 1'b0;
                end
            end
            MEASURE: begin
                // A rise landing exactly on the timeout count still counts as
                // a valid measurement, so it is checked first.
                if (w_rise) begin
                    period_d     = cnt_q;
                    high_time_d  = hi_lat_q;
                    meas_valid_d = 1'b1;
                    cnt_d        = c_one;
                    hi_lat_d     = '0;
                end else if (cnt_q == c_timeout) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + c_one;
                    if (w_fall) begin
                        hi_lat_d = cnt_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sync_q       <= '0;
            prev_q       <= 1'b0;
            cnt_q        <= '0;
            hi_lat_q     <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            meas_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            hi_lat_q     <= hi_lat_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            meas_valid_q <= meas_valid_d;
            timeout_q    <= timeout_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign timeout    = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_toggle_period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_toggle_period_meter
//  Description : Directed self-checking bench for toggle_period_meter.
//                sig_in is driven 1 time unit after a rising clk edge and
//                outputs are sampled at the same point, so a change made
//                after edge E is first seen by the synchronizer at E+1.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_toggle_period_meter;

    localparam int CNT_W = 16;
    localparam int S     = 2;      // synchronizer stages
    localparam int TMO   = 3000;   // timeout, kept small for run time

    logic             clk;
    logic             rst_n;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             timeout;

    int n_vec = 0;
    int n_err = 0;

    toggle_period_meter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (S),
        .TIMEOUT     (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sig_in     (sig_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Caller has just raised sig_in after edge E. The rise is detected in the
    // cycle after E+S, so the measurement registers load on edge E+S+1.
    // Returns positioned just after edge E+S+2.
    task automatic rise_check(input string tag, input logic exp_mv,
                              input int exp_per, input int exp_hi);
        hold(S);
        chk({tag, ".mv_early"}, 32'(meas_valid), 32'd0);
        hold(1);
        chk({tag, ".mv"},     32'(meas_valid), 32'(exp_mv));
        chk({tag, ".period"}, 32'(period),     exp_per);
        chk({tag, ".high"},   32'(high_time),  exp_hi);
        hold(1);
        chk({tag, ".mv_late"}, 32'(meas_valid), 32'd0);
    endtask

    initial begin
        // ---------------- reset ----------------
        rst_n  = 1'b0;
        sig_in = 1'b0;
        hold(3);
        chk("rst.period",  32'(period),     32'd0);
        chk("rst.high",    32'(high_time),  32'd0);
        chk("rst.mv",      32'(meas_valid), 32'd0);
        chk("rst.timeout", 32'(timeout),    32'd0);
        rst_n = 1'b1;
        hold(5);

        // ---------------- 1: symmetric 1001/1001 ----------------
        sig_in = 1'b1;
        rise_check("t1.arm", 1'b0, 0, 0);
        hold(1001 - (S + 2));
        sig_in = 1'b0;
        hold(1001);
        sig_in = 1'b1;
        rise_check("t1.m1", 1'b1, 2002, 1001);
        hold(1001 - (S + 2));
        sig_in = 1'b0;
        hold(1001);
        sig_in = 1'b1;
        rise_check("t1.m2", 1'b1, 2002, 1001);

        // ---------------- 2: asymmetric 300/700 ----------------
        hold(300 - (S + 2));
        sig_in = 1'b0;
        hold(700);
        sig_in = 1'b1;
        rise_check("t2.m1", 1'b1, 1000, 300);
        hold(300 - (S + 2));
        sig_in = 1'b0;
        hold(700);
        sig_in = 1'b1;
        rise_check("t2.m2", 1'b1, 1000, 300);

        // ---------------- 3: stop toggling -> timeout ----------------
        // Last rise raised after edge E; cnt reaches TMO after E+S+TMO,
        // timeout register loads on the following edge.
        hold(300 - (S + 2));                 // now at E+300
        sig_in = 1'b0;
        hold(TMO - 300 + S);                 // now at E+S+TMO
        chk("t3.tmo_before", 32'(timeout), 32'd0);
        hold(1);
        chk("t3.tmo",        32'(timeout),    32'd1);
        chk("t3.mv",         32'(meas_valid), 32'd0);
        chk("t3.period",     32'(period),     32'd1000);
        chk("t3.high",       32'(high_time),  32'd300);
        hold(50);
        chk("t3.tmo_level",  32'(timeout),    32'd1);
        sig_in = 1'b1;
        rise_check("t3.rearm", 1'b0, 1000, 300);
        chk("t3.tmo_clr",    32'(timeout),    32'd0);
        hold(400 - (S + 2));
        sig_in = 1'b0;
        hold(400);
        sig_in = 1'b1;
        rise_check("t3.m", 1'b1, 800, 400);

        // ---------------- 4: period exactly TIMEOUT ----------------
        hold(500 - (S + 2));
        sig_in = 1'b0;
        hold(TMO - 500);
        sig_in = 1'b1;
        rise_check("t4.m", 1'b1, TMO, 500);
        chk("t4.tmo", 32'(timeout), 32'd0);

        // ---------------- 5: reset mid-period, sig_in high ----------------
        hold(100);
        rst_n = 1'b0;
        #1;
        chk("t5.period", 32'(period),     32'd0);
        chk("t5.high",   32'(high_time),  32'd0);
        chk("t5.mv",     32'(meas_valid), 32'd0);
        chk("t5.tmo",    32'(timeout),    32'd0);
        hold(3);
        rst_n = 1'b1;                        // release after edge Er
        hold(S + 1);
        chk("t5.arm_mv0", 32'(meas_valid), 32'd0);
        hold(1);
        chk("t5.arm_mv1", 32'(meas_valid), 32'd0);   // now at Er+S+2
        hold(200 - (S + 2));
        sig_in = 1'b0;                       // Er+200
        hold(300);
        sig_in = 1'b1;                       // Er+500
        rise_check("t5.m", 1'b1, 500, 200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
